// File: rtl/i2c_regfile_pkg.sv
// i2c_regfile_pkg
//   Shared constants for the I2C application-side register bank: the fixed
//   address map above the general-purpose block, the unlock key, and the bit
//   positions inside the STATUS byte. It also provides a helper that packs
//   the STATUS byte.
package i2c_regfile_pkg;

    localparam logic [7:0] ADDR_ID     = 8'hF0;
    localparam logic [7:0] ADDR_STATUS = 8'hF1;
    localparam logic [7:0] ADDR_FLAGS  = 8'hF2;
    localparam logic [7:0] ADDR_MASK   = 8'hF3;
    localparam logic [7:0] ADDR_LOCK   = 8'hF4;

    localparam logic [7:0] UNLOCK_KEY  = 8'h5A;

    localparam int STATUS_ERR_BIT    = 0;
    localparam int STATUS_LOCKED_BIT = 6;
    localparam int STATUS_IRQ_BIT    = 7;

    function automatic logic [7:0] pack_status(input logic irq, input logic locked,
                                               input logic err);
        logic [7:0] s;
        s = 8'h00;
        s[STATUS_IRQ_BIT]    = irq;
        s[STATUS_LOCKED_BIT] = locked;
        s[STATUS_ERR_BIT]    = err;
        return s;
    endfunction

endpackage

// File: rtl/i2c_regfile_evt_capture.sv
// i2c_evt_capture
//   Captures rising edges of the hardware event inputs into sticky flags. The
//   flags are cleared by write-1-to-clear.
//   Ports:
//     clk, rst   - system clock, synchronous active-high reset
//     evt_i[7:0] - event inputs, synchronous to clk
//     clr_vec    - bits to clear (write data of a FLAGS write)
//     clr_stb    - qualifies clr_vec for one cycle
//     flags      - sticky event flags
//   A set and a clear on the same bit in the same cycle leave the bit set.
module i2c_evt_capture (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] evt_i,
    input  logic [7:0] clr_vec,
    input  logic       clr_stb,
    output logic [7:0] flags
);

    logic [7:0] evt_d;
    logic [7:0] rise;
    logic [7:0] clr_mask;

    assign rise     = evt_i & ~evt_d;
    assign clr_mask = clr_stb ? clr_vec : 8'h00;

    always_ff @(posedge clk) begin
        // evt_d tracks the input even during reset. An input that is already
        // high at reset release therefore does not count as an edge.
        evt_d <= evt_i;
        if (rst) begin
            flags <= 8'h00;
        end else begin
            flags <= (flags & ~clr_mask) | rise;
        end
    end

endmodule

// File: rtl/i2c_regfile.sv
// i2c_regfile
//   Register bank downstream of the I2C peripheral's application bus.
//   Address map: 0x00..NUM_REGS-1 GP R/W, 0xF0 ID, 0xF1 STATUS, 0xF2 FLAGS
//   (W1C), 0xF3 MASK, 0xF4 LOCK. Every other address reads 0x00. A write to
//   any other address is ignored and sets err.
//   Build option: define I2C_REGFILE_LOCK_EN to enable the write lock on the
//   GP registers (key 0x5A unlocks). Without it the GP registers are always
//   writable and LOCK reads 0x00.
//   Ports:
//     clk, rst      - system clock, synchronous active-high reset
//     addr, wdata   - application bus address / write data
//     we            - single-cycle write strobe
//     wr_rdn        - transfer direction (informational, unused)
//     rdata         - registered read data for addr
//     status        - {irq_o, locked, 5'b0, err}
//     evt_i         - hardware events; a rising edge sets a flag
//     cfg_o         - flattened GP registers, register n at [8n+7:8n]
//     irq_o         - registered |(flags & mask)
module i2c_regfile
    import i2c_regfile_pkg::*;
#(
    parameter int         NUM_REGS = 16,
    parameter logic [7:0] ID_VALUE = 8'hA7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            addr,
    input  logic [7:0]            wdata,
    input  logic                  we,
    input  logic                  wr_rdn,
    output logic [7:0]            rdata,
    output logic [7:0]            status,
    input  logic [7:0]            evt_i,
    output logic [NUM_REGS*8-1:0] cfg_o,
    output logic                  irq_o
);

    localparam logic [8:0] GP_LIMIT = 9'(NUM_REGS);

    logic [7:0] gp_q [NUM_REGS];
    logic [7:0] mask_q;
    logic [7:0] flags;
    logic       err_q;
    logic       locked;
    logic [7:0] rd_mux;
    logic [7:0] rdata_p1;
    logic       irq_p1;

    logic       hit_gp;
    logic       hit_fixed;
    logic       wr_gp;
    logic       wr_err;
    logic       wr_err_clr;
    logic       unused_wr_rdn;

    assign unused_wr_rdn = wr_rdn;

    assign hit_gp    = {1'b0, addr} < GP_LIMIT;
    // ID is deliberately left out of this set, so a write to ID reports an error.
    assign hit_fixed = (addr == ADDR_STATUS) || (addr == ADDR_FLAGS) ||
                       (addr == ADDR_MASK)   || (addr == ADDR_LOCK);
    assign wr_gp      = we && hit_gp && !locked;
    assign wr_err     = we && ((!hit_gp && !hit_fixed) || (hit_gp && locked));
    assign wr_err_clr = we && (addr == ADDR_STATUS) && wdata[STATUS_ERR_BIT];

    i2c_evt_capture u_evt (
        .clk     (clk),
        .rst     (rst),
        .evt_i   (evt_i),
        .clr_vec (wdata),
        .clr_stb (we && (addr == ADDR_FLAGS)),
        .flags   (flags)
    );

`ifdef I2C_REGFILE_LOCK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            locked <= 1'b1;
        end else if (we && (addr == ADDR_LOCK)) begin
            locked <= (wdata != UNLOCK_KEY);
        end
    end
`else
    assign locked = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < NUM_REGS; n++) gp_q[n] <= 8'h00;
            mask_q <= 8'h00;
            err_q  <= 1'b0;
        end else begin
            for (int n = 0; n < NUM_REGS; n++) begin
                if (wr_gp && ({1'b0, addr} == 9'(n))) gp_q[n] <= wdata;
            end
            if (we && (addr == ADDR_MASK)) mask_q <= wdata;
            // An error-setting write and a clear cannot share an address.
            if (wr_err) begin
                err_q <= 1'b1;
            end else if (wr_err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cfg
        assign cfg_o[8*g +: 8] = gp_q[g];
    end

    assign status = pack_status(irq_p1, locked, err_q);

    // Read mux. It has no side effects, so prefetching addr+1 is safe.
    always_comb begin
        rd_mux = 8'h00;
        if (hit_gp) begin
            for (int n = 0; n < NUM_REGS; n++) begin
                if ({1'b0, addr} == 9'(n)) rd_mux = gp_q[n];
            end
        end else begin
            case (addr)
                ADDR_ID:     rd_mux = ID_VALUE;
                ADDR_STATUS: rd_mux = status;
                ADDR_FLAGS:  rd_mux = flags;
                ADDR_MASK:   rd_mux = mask_q;
                ADDR_LOCK:   rd_mux = {7'b0, locked};
                default:     rd_mux = 8'h00;
            endcase
        end
    end

    // ---- stage p1: registered read data and interrupt ----
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_p1 <= 8'h00;
            irq_p1   <= 1'b0;
        end else begin
            rdata_p1 <= rd_mux;
            irq_p1   <= |(flags & mask_q);
        end
    end

    assign rdata = rdata_p1;
    assign irq_o = irq_p1;

endmodule

// File: tb/tb_i2c_regfile.sv
module tb_i2c_regfile;

    localparam int NUM_REGS = 16;
    localparam int CW       = NUM_REGS * 8;
    localparam logic [7:0] ID_VAL = 8'hA7;
`ifdef I2C_REGFILE_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    addr = 8'h00;
    logic [7:0]    wdata = 8'h00;
    logic          we = 1'b0;
    logic          wr_rdn = 1'b0;
    logic [7:0]    rdata;
    logic [7:0]    status;
    logic [7:0]    evt_i = 8'h00;
    logic [CW-1:0] cfg_o;
    logic          irq_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    i2c_regfile #(.NUM_REGS(NUM_REGS), .ID_VALUE(ID_VAL)) dut (
        .clk    (clk),
        .rst    (rst),
        .addr   (addr),
        .wdata  (wdata),
        .we     (we),
        .wr_rdn (wr_rdn),
        .rdata  (rdata),
        .status (status),
        .evt_i  (evt_i),
        .cfg_o  (cfg_o),
        .irq_o  (irq_o)
    );

    // Reference model: register contents as seen after each clock edge.
    logic [7:0] gp_m [NUM_REGS];
    logic [7:0] flags_m, mask_m, evt_prev, rd_m;
    bit         err_m, locked_m, irq_m;

    task automatic check(input string tag, input logic [CW-1:0] act,
                         input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] read_m(input logic [7:0] a);
        if (int'(a) < NUM_REGS) return gp_m[int'(a)];
        case (a)
            8'hF0:   return ID_VAL;
            8'hF1:   return {irq_m, locked_m, 5'b0, err_m};
            8'hF2:   return flags_m;
            8'hF3:   return mask_m;
            8'hF4:   return {7'b0, locked_m};
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_edge(input logic [7:0] a, input logic [7:0] d, input logic w,
                              input logic [7:0] e, input logic r);
        logic [7:0] next_rd;
        bit         next_irq;
        if (r) begin
            for (int i = 0; i < NUM_REGS; i++) gp_m[i] = 8'h00;
            flags_m = 8'h00; mask_m = 8'h00; err_m = 1'b0; locked_m = LOCK_EN;
            irq_m = 1'b0; rd_m = 8'h00; evt_prev = e;
            return;
        end
        next_rd  = read_m(a);
        next_irq = |(flags_m & mask_m);
        if (w) begin
            if (int'(a) < NUM_REGS) begin
                if (locked_m) err_m = 1'b1;
                else gp_m[int'(a)] = d;
            end else begin
                case (a)
                    8'hF0: err_m = 1'b1;
                    8'hF1: if (d[0]) err_m = 1'b0;
                    8'hF2: flags_m = flags_m & ~d;
                    8'hF3: mask_m = d;
                    8'hF4: if (LOCK_EN) locked_m = (d != 8'h5A);
                    default: err_m = 1'b1;
                endcase
            end
        end
        // Clear first, then set: a new edge beats a same-cycle clear.
        flags_m  = flags_m | (e & ~evt_prev);
        evt_prev = e;
        rd_m  = next_rd;
        irq_m = next_irq;
    endtask

    task automatic step(input logic [7:0] a, input logic [7:0] d, input logic w,
                        input logic [7:0] e, input logic r);
        logic [CW-1:0] cfg_m;
        @(negedge clk);
        addr = a; wdata = d; we = w; evt_i = e; rst = r; wr_rdn = w;
        @(posedge clk);
        model_edge(a, d, w, e, r);
        #1;
        for (int i = 0; i < NUM_REGS; i++) cfg_m[8*i +: 8] = gp_m[i];
        check("rdata", CW'(rdata), CW'(rd_m));
        check("irq_o", CW'(irq_o), CW'(irq_m));
        check("status", CW'(status), CW'({irq_m, locked_m, 5'b0, err_m}));
        check("cfg_o", cfg_o, cfg_m);
    endtask

    initial begin
        logic [7:0] ra, rd, re;
        logic       rw, rr;
        int         sel;

        step(8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
        step(8'h00, 8'h00, 1'b0, 8'h00, 1'b1);

        // Reset values
        step(8'hF0, 8'h00, 1'b0, 8'h00, 1'b0);
        check("rst_id", CW'(rdata), CW'(8'hA7));
        step(8'hF1, 8'h00, 1'b0, 8'h00, 1'b0);
        check("rst_status", CW'(rdata), CW'(LOCK_EN ? 8'h40 : 8'h00));
        step(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        check("rst_gp0", CW'(rdata), CW'(8'h00));
        check("rst_irq", CW'(irq_o), CW'(1'b0));

        // Lock / GP write
        step(8'h02, 8'h33, 1'b1, 8'h00, 1'b0);
        step(8'h02, 8'h00, 1'b0, 8'h00, 1'b0);
        check("gp2_first", CW'(rdata), CW'(LOCK_EN ? 8'h00 : 8'h33));
        check("err_locked", CW'(status[0]), CW'(LOCK_EN));
        step(8'hF4, 8'h5A, 1'b1, 8'h00, 1'b0);
        step(8'h02, 8'h33, 1'b1, 8'h00, 1'b0);
        step(8'h02, 8'h00, 1'b0, 8'h00, 1'b0);
        check("gp2_unlocked", CW'(rdata), CW'(8'h33));
        step(8'hF1, 8'h01, 1'b1, 8'h00, 1'b0);
        check("err_clr", CW'(status[0]), CW'(1'b0));

        // Event edge -> flag -> irq
        step(8'hF3, 8'h08, 1'b1, 8'h00, 1'b0);
        step(8'h00, 8'h00, 1'b0, 8'h08, 1'b0);
        check("irq_1cyc", CW'(irq_o), CW'(1'b0));
        step(8'hF2, 8'h00, 1'b0, 8'h00, 1'b0);
        check("flags_08", CW'(rdata), CW'(8'h08));
        check("irq_2cyc", CW'(irq_o), CW'(1'b1));
        step(8'hF2, 8'h08, 1'b1, 8'h00, 1'b0);
        step(8'hF2, 8'h00, 1'b0, 8'h00, 1'b0);
        check("irq_cleared", CW'(irq_o), CW'(1'b0));

        // Set wins over same-cycle clear
        step(8'h00, 8'h00, 1'b0, 8'h02, 1'b0);
        step(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        step(8'hF2, 8'h02, 1'b1, 8'h02, 1'b0);
        step(8'hF2, 8'h00, 1'b0, 8'h02, 1'b0);
        check("set_wins", CW'(rdata[1]), CW'(1'b1));

        // Unmapped writes
        step(8'hF1, 8'h01, 1'b1, 8'h00, 1'b0);
        step(8'hFF, 8'h11, 1'b1, 8'h00, 1'b0);
        check("err_ff", CW'(status[0]), CW'(1'b1));
        step(8'hFF, 8'h00, 1'b0, 8'h00, 1'b0);
        check("rd_ff", CW'(rdata), CW'(8'h00));
        step(8'hF1, 8'h01, 1'b1, 8'h00, 1'b0);
        step(8'h20, 8'h11, 1'b1, 8'h00, 1'b0);
        step(8'h20, 8'h00, 1'b0, 8'h00, 1'b0);
        check("rd_20", CW'(rdata), CW'(8'h00));
        check("err_20", CW'(status[0]), CW'(1'b1));

        // Reset between GP writes
        step(8'hF4, 8'h5A, 1'b1, 8'h00, 1'b0);
        step(8'h03, 8'h44, 1'b1, 8'h00, 1'b0);
        step(8'h04, 8'h55, 1'b1, 8'h00, 1'b1);
        step(8'h03, 8'h00, 1'b0, 8'h00, 1'b0);
        check("rst_mid_gp3", CW'(rdata), CW'(8'h00));
        step(8'h04, 8'h00, 1'b0, 8'h00, 1'b0);
        check("rst_mid_gp4", CW'(rdata), CW'(8'h00));
        step(8'hF4, 8'h5A, 1'b1, 8'h00, 1'b0);
        step(8'h05, 8'h77, 1'b1, 8'h00, 1'b0);
        step(8'h05, 8'h00, 1'b0, 8'h00, 1'b0);
        check("post_rst_gp5", CW'(rdata), CW'(8'h77));

        // Randomized traffic against the model
        re = 8'h00;
        for (int k = 0; k < 800; k++) begin
            sel = $urandom_range(0, 9);
            if (sel < 5)      ra = 8'($urandom_range(0, NUM_REGS + 3));
            else if (sel < 9) ra = 8'hF0 + 8'($urandom_range(0, 5));
            else              ra = 8'($urandom_range(0, 255));
            rd = ($urandom_range(0, 3) == 0) ? 8'h5A : 8'($urandom);
            rw = ($urandom_range(0, 1) == 1);
            re = re ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            rr = ($urandom_range(0, 63) == 0);
            step(ra, rd, rw, re, rr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
